// File: rtl/feistel_core_iter.sv
// Iterative DES Feistel core: one 64-bit block per ROUNDS/RPC RUN cycles,
// with RPC f-function stages unrolled per cycle and valid/ready on both sides.
module feistel_core_iter #(
   parameter int ROUNDS = 16,
   parameter int RPC    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [63:0]           in_data,
   input  logic                  in_decrypt,
   input  logic [ROUNDS*48-1:0]  round_keys,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [63:0]           out_data,
   output logic [1:0]            dbg_state
);

   // Handshake semantics: a transfer happens on a rising edge where valid and
   // ready are both high. A producer holds valid (and its data) until that edge;
   // ready may be raised or dropped freely. Here in_ready is high only in IDLE,
   // and out_valid/out_data are held from the DONE entry until out_ready.

   localparam int CW = $clog2(ROUNDS + 1);

   localparam bit PARAM_OK = (ROUNDS >= 1) && (ROUNDS <= 16) && (RPC >= 1) &&
                             (RPC <= ROUNDS) &&
                             ((ROUNDS % ((RPC >= 1) ? RPC : 1)) == 0);

   if (!PARAM_OK) begin : g_param_err
      $error("feistel_core_iter: ROUNDS must be 1..16 and RPC must divide ROUNDS");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int IP_T [0:63] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };

   localparam int FP_T [0:63] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25
   };

   localparam int E_T [0:47] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int P_T [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   // Each box is stored row-major: index = row*16 + col, row = {b1,b6}, col = b2..b5.
   localparam int SBOX [0:7][0:63] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   // Table entries are 1-based bit numbers counted from the MSB, as in the DES text.
   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] p;
      logic [5:0]  six;
      e = '0;
      s = '0;
      p = '0;
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ k;
      for (int i = 0; i < 8; i++) begin
         six = e[47-6*i -: 6];
         s[31-4*i -: 4] = 4'(SBOX[i][{six[5], six[0], six[4:1]}]);
      end
      for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
      return p;
   endfunction

   // Decrypt walks the schedule backwards; out-of-range rounds (only reachable
   // outside RUN) fall back to K1 so the select never leaves the key vector.
   function automatic logic [47:0] sel_key(input logic [ROUNDS*48-1:0] keys,
                                           input logic dec, input int j);
      int idx;
      if (j >= ROUNDS) idx = 0;
      else if (dec)    idx = ROUNDS - 1 - j;
      else             idx = j;
      return keys[48*idx +: 48];
   endfunction

   state_t                 state_q;
   logic [31:0]            l_q, r_q;
   logic [ROUNDS*48-1:0]   key_q;
   logic                   mode_q;
   logic [CW-1:0]          cnt_q;
   logic [31:0]            l_n, r_n, r_tmp;
   logic                   last_step;

   assign in_ready  = (state_q == IDLE);
   assign dbg_state = state_q;
   assign last_step = ((cnt_q + CW'(RPC)) == CW'(ROUNDS));

   // RPC chained Feistel rounds starting at global round cnt_q.
   always_comb begin
      l_n   = l_q;
      r_n   = r_q;
      r_tmp = '0;
      for (int k = 0; k < RPC; k++) begin
         r_tmp = r_n;
         r_n   = l_n ^ f_func(r_n, sel_key(key_q, mode_q, int'(cnt_q) + k));
         l_n   = r_tmp;
      end
   end

   // Control FSM and datapath registers: load on accept, iterate in RUN, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         l_q       <= '0;
         r_q       <= '0;
         key_q     <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  {l_q, r_q} <= ip_perm(in_data);
                  mode_q     <= in_decrypt;
                  key_q      <= round_keys;
                  cnt_q      <= '0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               l_q   <= l_n;
               r_q   <= r_n;
               cnt_q <= cnt_q + CW'(RPC);
               if (last_step) begin
                  out_data  <= fp_perm({r_n, l_n});
                  out_valid <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_feistel_core_iter.sv
// Directed bench for feistel_core_iter: known DES vectors, latency, backpressure,
// input isolation, mid-block reset and an unroll sweep over RPC = 1,2,4,8,16.
module tb_feistel_core_iter;

   localparam int NI = 5;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [63:0]  in_data;
   logic         in_decrypt;
   logic [767:0] round_keys;
   logic         out_ready;
   logic         in_ready_v  [NI];
   logic         out_valid_v [NI];
   logic [63:0]  out_data_v  [NI];
   logic [1:0]   dbg_v       [NI];

   int n_assert = 0;
   int n_fail   = 0;

   // Instance 0 (RPC=1) is the main DUT; the others share inputs for the sweep.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      feistel_core_iter #(.ROUNDS(16), .RPC(1 << g)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready_v[g]),
         .in_data    (in_data),
         .in_decrypt (in_decrypt),
         .round_keys (round_keys),
         .out_valid  (out_valid_v[g]),
         .out_ready  (out_ready),
         .out_data   (out_data_v[g]),
         .dbg_state  (dbg_v[g])
      );
   end

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SH [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Key schedule: K(i+1) lands at bits [48*i+47 : 48*i].
   function automatic logic [767:0] key_sched(input logic [63:0] key);
      logic [55:0]  cd;
      logic [27:0]  c, d;
      logic [47:0]  k;
      logic [767:0] ks;
      cd = '0;
      k  = '0;
      ks = '0;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SH[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
         ks[48*r +: 48] = k;
      end
      return ks;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // One-cycle input pulse on the main DUT (it is checked to be in IDLE first).
   task automatic accept0(input string tag, input logic [63:0] d, input logic dec,
                          input logic [767:0] keys);
      chk({tag, "_in_ready_before"}, 64'(in_ready_v[0]), 64'd1);
      in_data    = d;
      in_decrypt = dec;
      round_keys = keys;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      chk({tag, "_in_ready_after"}, 64'(in_ready_v[0]), 64'd0);
   endtask

   task automatic wait_out0(output int lat);
      lat = 0;
      while (!out_valid_v[0] && lat < 64) begin
         step();
         lat++;
      end
   endtask

   logic [63:0]  key_v [4] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73,
                               64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
   logic [63:0]  pt_v  [4] = '{64'h0123456789ABCDEF, 64'h8787878787878787,
                               64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
   logic [63:0]  ct_v  [4] = '{64'h85E813540F0AB405, 64'h0000000000000000,
                               64'h8CA64DE9C1B123A7, 64'h7359B2163E4EDC58};

   logic [767:0] ks1;
   int           lat;
   logic         spurious;
   int           seen   [NI];
   int           t_first[NI];
   int           t_sec  [NI];
   logic [63:0]  d_first[NI];
   logic [63:0]  d_sec  [NI];

   // Directed sequence
   initial begin
      in_valid   = 1'b0;
      in_data    = '0;
      in_decrypt = 1'b0;
      round_keys = '0;
      out_ready  = 1'b1;
      rst_n      = 1'b0;
      ks1        = key_sched(64'h133457799BBCDFF1);

      // Reset state
      step();
      chk("rst_in_ready",  64'(in_ready_v[0]),  64'd1);
      chk("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("rst_out_data",  out_data_v[0],       64'd0);
      chk("rst_state",     64'(dbg_v[0]),       64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", 64'(in_ready_v[0]), 64'd1);

      // Test 1: standard encrypt, latency 16
      accept0("t1", 64'h0123456789ABCDEF, 1'b0, ks1);
      chk("t1_state_run", 64'(dbg_v[0]), 64'd1);
      wait_out0(lat);
      chk("t1_latency", 64'(lat), 64'd16);
      chk("t1_data", out_data_v[0], 64'h85E813540F0AB405);
      chk("t1_state_done", 64'(dbg_v[0]), 64'd2);
      step();
      chk("t1_out_valid_drop", 64'(out_valid_v[0]), 64'd0);
      chk("t1_in_ready_back", 64'(in_ready_v[0]), 64'd1);

      // Test 2: decrypt back to plaintext
      accept0("t2", 64'h85E813540F0AB405, 1'b1, ks1);
      wait_out0(lat);
      chk("t2_latency", 64'(lat), 64'd16);
      chk("t2_data", out_data_v[0], 64'h0123456789ABCDEF);
      step();

      // Test 3: backpressure for 5 cycles, in_valid during DONE is ignored
      out_ready = 1'b0;
      accept0("t3", 64'h0123456789ABCDEF, 1'b0, ks1);
      wait_out0(lat);
      chk("t3_latency", 64'(lat), 64'd16);
      in_valid = 1'b1;
      in_data  = 64'hDEADBEEFCAFEF00D;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_hold_valid_%0d", i), 64'(out_valid_v[0]), 64'd1);
         chk($sformatf("t3_hold_data_%0d", i), out_data_v[0], 64'h85E813540F0AB405);
         chk($sformatf("t3_hold_in_ready_%0d", i), 64'(in_ready_v[0]), 64'd0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("t3_release_valid", 64'(out_valid_v[0]), 64'd0);
      chk("t3_release_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("t3_data_kept", out_data_v[0], 64'h85E813540F0AB405);
      step();
      chk("t3_no_extra_accept", 64'(in_ready_v[0]), 64'd1);
      chk("t3_no_extra_valid", 64'(out_valid_v[0]), 64'd0);

      // Test 4: inputs scrambled right after accept
      accept0("t4", 64'h0123456789ABCDEF, 1'b0, ks1);
      in_data    = {$urandom, $urandom};
      in_decrypt = 1'b1;
      for (int w = 0; w < 24; w++) round_keys[32*w +: 32] = $urandom;
      wait_out0(lat);
      chk("t4_latency", 64'(lat), 64'd16);
      chk("t4_data", out_data_v[0], 64'h85E813540F0AB405);
      step();

      // Test 5: reset pulse during RUN aborts the block
      accept0("t5", 64'h0123456789ABCDEF, 1'b0, ks1);
      for (int i = 0; i < 7; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("t5_rst_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("t5_rst_state", 64'(dbg_v[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         spurious = spurious | out_valid_v[0];
      end
      chk("t5_no_spurious", 64'(spurious), 64'd0);
      accept0("t5b", 64'h0123456789ABCDEF, 1'b0, ks1);
      wait_out0(lat);
      chk("t5b_latency", 64'(lat), 64'd16);
      chk("t5b_data", out_data_v[0], 64'h85E813540F0AB405);
      step();

      // Test 6a: every instance, every vector, both directions
      do_reset();
      for (int v = 0; v < 4; v++) begin
         for (int dec = 0; dec < 2; dec++) begin
            in_data    = (dec != 0) ? ct_v[v] : pt_v[v];
            in_decrypt = (dec != 0);
            round_keys = key_sched(key_v[v]);
            in_valid   = 1'b1;
            step();
            in_valid = 1'b0;
            for (int g = 0; g < NI; g++) begin
               seen[g]    = 0;
               t_first[g] = -1;
               d_first[g] = '0;
            end
            for (int cyc = 1; cyc <= 40; cyc++) begin
               step();
               for (int g = 0; g < NI; g++) begin
                  if (out_valid_v[g] && seen[g] == 0) begin
                     seen[g]    = 1;
                     t_first[g] = cyc;
                     d_first[g] = out_data_v[g];
                  end
               end
            end
            for (int g = 0; g < NI; g++) begin
               chk($sformatf("sweep_lat_rpc%0d_v%0d_d%0d", 1 << g, v, dec),
                   64'(t_first[g]), 64'(16 >> g));
               chk($sformatf("sweep_data_rpc%0d_v%0d_d%0d", 1 << g, v, dec),
                   d_first[g], (dec != 0) ? pt_v[v] : ct_v[v]);
            end
         end
      end

      // Test 6b: back-to-back streaming, period N+2
      in_data    = pt_v[0];
      in_decrypt = 1'b0;
      round_keys = ks1;
      in_valid   = 1'b1;
      for (int g = 0; g < NI; g++) begin
         seen[g]    = 0;
         t_first[g] = -1;
         t_sec[g]   = -1;
         d_first[g] = '0;
         d_sec[g]   = '0;
      end
      for (int cyc = 1; cyc <= 60; cyc++) begin
         step();
         for (int g = 0; g < NI; g++) begin
            if (out_valid_v[g]) begin
               if (seen[g] == 0) begin
                  t_first[g] = cyc;
                  d_first[g] = out_data_v[g];
               end else if (seen[g] == 1) begin
                  t_sec[g] = cyc;
                  d_sec[g] = out_data_v[g];
               end
               seen[g]++;
            end
         end
      end
      in_valid = 1'b0;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("stream_first_rpc%0d", 1 << g), 64'(t_first[g]), 64'(1 + (16 >> g)));
         chk($sformatf("stream_period_rpc%0d", 1 << g), 64'(t_sec[g] - t_first[g]),
             64'((16 >> g) + 2));
         chk($sformatf("stream_data0_rpc%0d", 1 << g), d_first[g], ct_v[0]);
         chk($sformatf("stream_data1_rpc%0d", 1 << g), d_sec[g], ct_v[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
